// File: rtl/spi_slave_param.sv
// Parametrised SPI slave front-end. It turns MOSI frames into {cmd, payload}
// words for the RAM and shifts RAM read data back out on MISO.
module spi_slave_param #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter int unsigned TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned FRAME_W = DATA_W + 2;
  // One counter covers the frame bits plus the two-cycle output pipeline,
  // the tx_valid wait and the MISO shift.
  localparam int unsigned CNT_MAX = (FRAME_W + 1 > TX_TIMEOUT) ? FRAME_W + 1 : TX_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    WAIT_SS
  } state_t;

  // Sub-phase of the shifting states: receive, wait for RAM data, drive MISO.
  typedef enum logic [1:0] {
    PH_RX,
    PH_WAIT,
    PH_TX
  } phase_t;

  state_t             state, state_n;
  phase_t             phase, phase_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [FRAME_W-1:0] rx_sh, rx_sh_n;
  logic [DATA_W-1:0]  tx_sh, tx_sh_n;
  logic               pending, pending_n;
  logic [DATA_W+1:0]  rx_data_n;
  logic               rx_valid_n, frame_err_n, miso_n, busy_n;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= PH_RX;
      cnt       <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      pending   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      MISO      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      cnt       <= cnt_n;
      rx_sh     <= rx_sh_n;
      tx_sh     <= tx_sh_n;
      pending   <= pending_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
      MISO      <= miso_n;
      busy      <= busy_n;
    end
  end

  // Next-state and next-output logic; pulses and MISO default low.
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    cnt_n       = cnt;
    rx_sh_n     = rx_sh;
    tx_sh_n     = tx_sh;
    pending_n   = pending;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;
    miso_n      = 1'b0;

    unique case (state)
      IDLE: begin
        if (!SS_n) begin
          state_n = CHK_CMD;
          phase_n = PH_RX;
          cnt_n   = '0;
        end
      end

      CHK_CMD: begin
        if (SS_n) begin
          frame_err_n = 1'b1;
          state_n     = IDLE;
        end else if (!MOSI) begin
          state_n = WRITE;
        end else if (pending) begin
          state_n = READ_DATA;
        end else begin
          state_n = READ_ADD;
        end
      end

      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) begin
          // Deselect mid-frame: any pending read address is left as it is.
          frame_err_n = 1'b1;
          state_n     = IDLE;
          cnt_n       = '0;
        end else begin
          unique case (phase)
            PH_RX: begin
              if (cnt < CNT_W'(FRAME_W)) begin
                rx_sh_n = LSB_FIRST ? {MOSI, rx_sh[FRAME_W-1:1]}
                                    : {rx_sh[FRAME_W-2:0], MOSI};
                cnt_n   = cnt + CNT_W'(1);
              end else if (cnt == CNT_W'(FRAME_W)) begin
                cnt_n = cnt + CNT_W'(1);
              end else begin
                rx_data_n  = rx_sh;
                rx_valid_n = 1'b1;
                cnt_n      = '0;
                if (state == WRITE) begin
                  state_n = WAIT_SS;
                end else if (state == READ_ADD) begin
                  pending_n = 1'b1;
                  state_n   = WAIT_SS;
                end else begin
                  pending_n = 1'b0;
                  phase_n   = PH_WAIT;
                end
              end
            end

            PH_WAIT: begin
              // tx_valid takes priority over the last timeout cycle.
              if (tx_valid) begin
                tx_sh_n = tx_data;
                cnt_n   = '0;
                phase_n = PH_TX;
              end else if (cnt == CNT_W'(TX_TIMEOUT - 1)) begin
                frame_err_n = 1'b1;
                pending_n   = 1'b0;
                cnt_n       = '0;
                state_n     = WAIT_SS;
              end else begin
                cnt_n = cnt + CNT_W'(1);
              end
            end

            PH_TX: begin
              if (cnt < CNT_W'(DATA_W)) begin
                miso_n  = LSB_FIRST ? tx_sh[0] : tx_sh[DATA_W-1];
                tx_sh_n = LSB_FIRST ? (tx_sh >> 1) : (tx_sh << 1);
                cnt_n   = cnt + CNT_W'(1);
              end else begin
                cnt_n   = '0;
                state_n = WAIT_SS;
              end
            end

            default: state_n = IDLE;
          endcase
        end
      end

      WAIT_SS: begin
        if (SS_n) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: one MSB-first 8-bit instance and one LSB-first
// 16-bit instance, checked against a frame-timeline reference model.
module tb_spi_slave_param;

  localparam int unsigned TO8  = 4;
  localparam int unsigned TO16 = 5;

  logic        clk = 1'b0;
  logic        rst_n, SS_n, MOSI, tx_valid;
  logic [7:0]  tx_data8;
  logic [15:0] tx_data16;
  logic        miso8, rv8, fe8, busy8;
  logic [9:0]  rxd8;
  logic        miso16, rv16, fe16, busy16;
  logic [17:0] rxd16;

  bit          sel16;
  logic        o_miso, o_rv, o_fe, o_busy;
  logic [17:0] o_rxd;

  int passed = 0;
  int checks = 0;

  // Reference model state: pending read address and last received word.
  bit          m_pend8, m_pend16;
  logic [17:0] m_rx8, m_rx16;

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(8), .LSB_FIRST(1'b0), .TX_TIMEOUT(TO8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso8),
    .rx_data(rxd8), .rx_valid(rv8), .tx_data(tx_data8), .tx_valid(tx_valid),
    .frame_err(fe8), .busy(busy8)
  );

  spi_slave_param #(.DATA_W(16), .LSB_FIRST(1'b1), .TX_TIMEOUT(TO16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso16),
    .rx_data(rxd16), .rx_valid(rv16), .tx_data(tx_data16), .tx_valid(tx_valid),
    .frame_err(fe16), .busy(busy16)
  );

  // Observe whichever instance is under test.
  always_comb begin
    o_miso = sel16 ? miso16 : miso8;
    o_rv   = sel16 ? rv16   : rv8;
    o_fe   = sel16 ? fe16   : fe8;
    o_busy = sel16 ? busy16 : busy8;
    o_rxd  = sel16 ? rxd16  : {8'b0, rxd8};
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_pend8 = 1'b0; m_pend16 = 1'b0; m_rx8 = '0; m_rx16 = '0;
  endtask

  // One frame: SS_n low for edges 0..r_edge-1, high at r_edge; tx_valid
  // pulses at edge v_edge (-1 = never). Bit k of each trace is the output
  // seen in the cycle after edge k.
  task automatic do_frame(input string tag, input bit mode, input logic [17:0] word,
                          input int r_edge, input int v_edge, input logic [15:0] txd);
    int w, to, vr, fw;
    bit lsb, pend;
    logic [17:0]  rx_exp;
    logic [127:0] rv_t, fe_t, mi_t, bz_t, rv_e, fe_e, mi_e, bz_e;
    w   = sel16 ? 16 : 8;
    to  = sel16 ? int'(TO16) : int'(TO8);
    lsb = sel16;
    fw  = w + 2;
    vr  = w + 5;
    pend   = sel16 ? m_pend16 : m_pend8;
    rx_exp = sel16 ? m_rx16 : m_rx8;

    rv_e = '0; fe_e = '0; mi_e = '0; bz_e = '0;
    for (int k = 0; k < r_edge; k++) bz_e[k] = 1'b1;
    if (r_edge <= vr) begin
      fe_e[r_edge] = 1'b1;
    end else begin
      rv_e[vr] = 1'b1;
      rx_exp   = word;
      if (mode) begin
        if (!pend) begin
          pend = 1'b1;
        end else begin
          pend = 1'b0;
          if (v_edge > vr && v_edge <= vr + to && v_edge < r_edge) begin
            for (int i = 1; i <= w; i++)
              if (v_edge + i < r_edge) mi_e[v_edge+i] = lsb ? txd[i-1] : txd[w-i];
            if (r_edge <= v_edge + w + 1) fe_e[r_edge] = 1'b1;
          end else if (r_edge > vr + to) begin
            fe_e[vr+to] = 1'b1;
          end else begin
            fe_e[r_edge] = 1'b1;
          end
        end
      end
    end

    tx_data8 = txd[7:0];
    tx_data16 = txd;
    rv_t = '0; fe_t = '0; mi_t = '0; bz_t = '0;
    for (int k = 0; k <= r_edge; k++) begin
      SS_n     = (k >= r_edge);
      tx_valid = (k == v_edge);
      if (k == 1)                MOSI = mode;
      else if (k >= 2 && k <= fw + 1) MOSI = lsb ? word[k-2] : word[fw-1-(k-2)];
      else                       MOSI = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      rv_t[k] = o_rv; fe_t[k] = o_fe; mi_t[k] = o_miso; bz_t[k] = o_busy;
    end
    tx_valid = 1'b0;

    if (sel16) begin m_pend16 = pend; m_rx16 = rx_exp; end
    else       begin m_pend8  = pend; m_rx8  = rx_exp; end

    check({tag, " rx_valid"},  rv_t, rv_e);
    check({tag, " frame_err"}, fe_t, fe_e);
    check({tag, " miso"},      mi_t, mi_e);
    check({tag, " busy"},      bz_t, bz_e);
    check({tag, " rx_data"},   o_rxd, rx_exp);
  endtask

  initial begin
    int w, to, vr, r, v, hits;
    bit mode;
    logic [17:0] word, mask;

    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0;
    tx_data8 = '0; tx_data16 = '0; sel16 = 1'b0;
    m_pend8 = 1'b0; m_pend16 = 1'b0; m_rx8 = '0; m_rx16 = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset8",  {miso8, rv8, fe8, busy8, rxd8}, '0);
    check("reset16", {miso16, rv16, fe16, busy16, rxd16}, '0);
    rst_n = 1'b1;

    // 8-bit MSB-first instance: rx_valid after edge 13, timeout 4.
    do_frame("wr_addr", 1'b0, 18'h0A5, 16, -1, 16'h0);

    // Reset in the middle of a write frame, just before edge t5.
    for (int k = 0; k < 5; k++) begin
      SS_n = 1'b0;
      MOSI = (k == 1) ? 1'b0 : 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("rst_async", {o_miso, o_rv, o_fe, o_busy, o_rxd}, '0);
    @(posedge clk);
    @(negedge clk);
    check("rst_edge", {o_miso, o_rv, o_fe, o_busy, o_rxd}, '0);
    SS_n = 1'b1;
    rst_n = 1'b1;
    m_pend8 = 1'b0; m_pend16 = 1'b0; m_rx8 = '0; m_rx16 = '0;
    hits = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (o_rv || o_fe || o_busy) hits++;
    end
    check("rst_quiet", 128'(hits), '0);

    do_frame("wr_addr2",   1'b0, 18'h15A, 15, -1, 16'h0);
    do_frame("rd_addr",    1'b1, 18'h230, 15, -1, 16'h0);
    do_frame("rd_data",    1'b1, 18'h3A7, 25, 15, 16'h00C3);
    do_frame("rd_addr_t",  1'b1, 18'h211, 15, -1, 16'h0);
    do_frame("timeout",    1'b1, 18'h35C, 20, -1, 16'h0);
    do_frame("after_to",   1'b1, 18'h2F0, 15, -1, 16'h0);
    do_frame("abort_wr",   1'b0, 18'h0FF,  7, -1, 16'h0);
    do_frame("abort_tx",   1'b1, 18'h3C3, 18, 14, 16'h00A5);
    do_frame("chk_abort",  1'b1, 18'h255,  1, -1, 16'h0);
    do_frame("rd_addr_c",  1'b1, 18'h201, 15, -1, 16'h0);
    do_frame("to_tie",     1'b1, 18'h399, 27, 17, 16'h005A);
    do_frame("rd_addr_w",  1'b1, 18'h2AA, 15, -1, 16'h0);
    do_frame("abort_wait", 1'b1, 18'h3AA, 15, -1, 16'h0);

    w = 8; to = int'(TO8); vr = w + 5; mask = 18'h003FF;
    for (int n = 0; n < 8; n++) begin
      mode = 1'($urandom);
      word = 18'($urandom) & mask;
      r = ($urandom_range(0, 1) == 0) ? vr + to + w + 3 : int'($urandom_range(vr + to + w + 4, 1));
      v = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(vr + to + 1, vr - 1));
      do_frame($sformatf("rand8_%0d", n), mode, word, r, v, 16'($urandom) & 16'h00FF);
    end

    // 16-bit LSB-first instance: rx_valid after edge 21, timeout 5.
    do_reset();
    sel16 = 1'b1;
    do_frame("wr16",       1'b0, {2'b01, 16'h8001}, 24, -1, 16'h0);
    do_frame("rd_addr16",  1'b1, {2'b10, 16'h1234}, 23, -1, 16'h0);
    do_frame("rd_data16",  1'b1, {2'b11, 16'hBEEF}, 42, 23, 16'hC35A);
    do_frame("rd_addr16t", 1'b1, {2'b10, 16'h0F0F}, 23, -1, 16'h0);
    do_frame("timeout16",  1'b1, {2'b11, 16'h7001}, 29, -1, 16'h0);

    w = 16; to = int'(TO16); vr = w + 5; mask = 18'h3FFFF;
    for (int n = 0; n < 6; n++) begin
      mode = 1'($urandom);
      word = 18'($urandom) & mask;
      r = ($urandom_range(0, 1) == 0) ? vr + to + w + 3 : int'($urandom_range(vr + to + w + 4, 1));
      v = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(vr + to + 1, vr - 1));
      do_frame($sformatf("rand16_%0d", n), mode, word, r, v, 16'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised SPI slave front-end: deserialises MOSI frames into (command, payload) words for the single-port RAM and serialises RAM read data onto MISO.
- Generalises the fixed 8-bit-payload slave with:
  - configurable payload width and bit order;
  - read-address/read-data sequencing enforcement;
  - a read-data timeout;
  - an explicit frame-error pulse.
- Sits between the SPI pins and the RAM inside the SPI wrapper.

Parameters:
- DATA_W, 8, payload width in bits; rx_data is DATA_W+2 bits (2-bit command + payload).
- LSB_FIRST, 0, bit order. 0 = MSB first on MOSI and MISO; 1 = LSB first.
- TX_TIMEOUT, 16, maximum number of cycles to wait for tx_valid in READ_DATA before aborting; range 1..255.

Ports:
- clk  in  1  system/SPI clock; all sampling on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  serial data in.
- MISO  out  1  serial data out.
- rx_data  out  DATA_W+2  {cmd[1:0], payload}: 00 wr addr, 01 wr data, 10 rd addr, 11 rd data.
- rx_valid  out  1  one-cycle pulse; rx_data valid.
- tx_data  in  DATA_W  read data from RAM.
- tx_valid  in  1  tx_data valid; sampled only in READ_DATA while waiting.
- frame_err  out  1  one-cycle pulse on aborted or illegal frame.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, any state): MISO=0, rx_valid=0, rx_data=0, frame_err=0, busy=0, state=IDLE, rd_addr_pending=0, all counters=0. Reset mid-frame discards the frame and emits no pulses.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_SS.
- IDLE -> CHK_CMD at the edge sampling SS_n=0 (edge t0).
- CHK_CMD samples MOSI at t1:
  - 0 -> WRITE.
  - 1 and rd_addr_pending=0 -> READ_ADD.
  - 1 and rd_addr_pending=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA shift DATA_W+2 bits sampled at t2..t(DATA_W+3), placed in the order set by LSB_FIRST.
- rx_data/rx_valid are registered: rx_data loads and rx_valid pulses high for exactly 1 cycle after edge t(DATA_W+5). With DATA_W=8, rx_valid is high in the cycle after t13.
- Command bits are passed as received; no check of cmd against the state.
- Successful READ_ADD frame sets rd_addr_pending=1. Successful READ_DATA frame clears it.
- READ_DATA after rx_valid: wait for tx_valid, counting cycles.
  - tx_valid seen: latch tx_data, then drive DATA_W bits on MISO, one per cycle starting the cycle after the latch, in LSB_FIRST order. Then -> WAIT_SS with MISO=0.
  - Count reaches TX_TIMEOUT without tx_valid: frame_err pulse, rd_addr_pending cleared, -> WAIT_SS.
  - tx_valid and the final timeout cycle coincide: tx_valid wins.
- MISO is 0 in every cycle it is not shifting read data.
- SS_n=1 sampled in any state other than IDLE/WAIT_SS:
  - Before rx_valid: frame_err pulse, no rx_valid, rd_addr_pending unchanged, -> IDLE.
  - During MISO shifting: frame_err pulse, -> IDLE; rd_addr_pending stays cleared.
- WAIT_SS: extra MOSI bits are ignored; SS_n=1 -> IDLE with no error.
- Back-to-back frames: SS_n high for 1 cycle then low again is legal.
- rx_valid and frame_err are never high in the same cycle.

Test Plan:
- Reset mid-frame: assert rst_n=0 at t5 of a write frame -> MISO, rx_valid, rx_data, frame_err all 0 next edge; no rx_valid after rst_n releases.
- Write address: DATA_W=8, SS_n fall, MOSI 0 then bits 00_1010_0101 -> rx_data=10'h0A5, rx_valid high 1 cycle after t13, busy until SS_n high.
- Read pair: rd addr frame 10_0011_0000 -> rx_data=10'h230, pending=1. Next frame, mode bit 1 -> READ_DATA; rx_data=10'h3xx. tx_valid with tx_data=8'hC3 two cycles later -> MISO 1,1,0,0,0,0,1,1. Then pending=0.
- Timeout: TX_TIMEOUT=4, rd data frame, no tx_valid -> frame_err pulse 4 cycles after rx_valid, MISO stays 0, next read frame enters READ_ADD.
- Early abort: SS_n rises at t7 of a write frame -> frame_err single pulse, no rx_valid, state IDLE.
- Variant: DATA_W=16, LSB_FIRST=1, write data 16'h8001 -> rx_data={2'b01,16'h8001}, rx_valid after t21.
